// File: rtl/ccm_ctr_fake_aes.sv
// CCM counter-mode keystream generator. Counter blocks are built from the flag and nonce fields plus a block counter.
// Each block then runs through a fixed-latency XOR/rotate stand-in for AES.
module ccm_ctr_fake_aes #(
  parameter int WIDTH_KEY            = 128,
  parameter int WIDTH_FLAG           = 8,
  parameter int WIDTH_SECTOR_ID      = 4,
  parameter int WIDTH_FRAME_IDX      = 48,
  parameter int WIDTH_START_SLOT_IDX = 4,
  parameter int WIDTH_ADDRESS        = 8,
  parameter int ROUNDS               = 10
) (
  input  logic                            clk,
  input  logic                            kill,
  input  logic [WIDTH_KEY-1:0]            key_aes,
  input  logic [WIDTH_FLAG-1:0]           ccm_ctr_flag,
  input  logic [WIDTH_SECTOR_ID-1:0]      nonce_sector_id,
  input  logic [WIDTH_FRAME_IDX-1:0]      nonce_frame_id,
  input  logic [WIDTH_START_SLOT_IDX-1:0] nonce_start_slot_idx,
  input  logic [WIDTH_ADDRESS-1:0]        nonce_addr_idx,
  input  logic                            in_stream_idx,
  input  logic                            in_ready,
  output logic                            out_stream_idx,
  output logic [WIDTH_KEY-1:0]            encrypt_ctr_data,
  output logic                            encrypt_en
);

  localparam int WIDTH_COUNTER = WIDTH_KEY - WIDTH_FLAG - WIDTH_SECTOR_ID - WIDTH_FRAME_IDX
                                 - WIDTH_START_SLOT_IDX - WIDTH_ADDRESS;

  logic                     prev_ready;
  logic [WIDTH_COUNTER-1:0] ctr;
  logic [WIDTH_COUNTER-1:0] ctr_next;
  logic [WIDTH_KEY-1:0]     stage [0:ROUNDS];
  logic [ROUNDS:0]          valid;
  logic [ROUNDS:0]          tag;

  function automatic logic [WIDTH_KEY-1:0] fake_round(input logic [WIDTH_KEY-1:0] d,
                                                      input logic [WIDTH_KEY-1:0] k);
    logic [WIDTH_KEY-1:0] x;
    x = d ^ k;
    return {x[WIDTH_KEY-9:0], x[WIDTH_KEY-1:WIDTH_KEY-8]};
  endfunction

  // A request with no request on the previous edge starts a new burst at ctr=1
  always_comb begin
    ctr_next = prev_ready ? ctr + WIDTH_COUNTER'(1) : WIDTH_COUNTER'(1);
  end

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      prev_ready <= 1'b0;
      ctr        <= '0;
      stage[0]   <= '0;
      valid[0]   <= 1'b0;
      tag[0]     <= 1'b0;
    end else begin
      prev_ready <= in_ready;
      valid[0]   <= in_ready;
      if (in_ready) begin
        ctr      <= ctr_next;
        tag[0]   <= in_stream_idx;
        stage[0] <= {ccm_ctr_flag, nonce_sector_id, nonce_frame_id,
                     nonce_start_slot_idx, nonce_addr_idx, ctr_next};
      end
    end
  end

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      for (int i = 1; i <= ROUNDS; i++) begin
        stage[i] <= '0;
      end
      valid[ROUNDS:1] <= '0;
      tag[ROUNDS:1]   <= '0;
    end else begin
      for (int i = 1; i <= ROUNDS; i++) begin
        stage[i] <= fake_round(stage[i-1], key_aes);
      end
      valid[ROUNDS:1] <= valid[ROUNDS-1:0];
      tag[ROUNDS:1]   <= tag[ROUNDS-1:0];
    end
  end

  // The output register holds the last block and tag between strobes
  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      encrypt_en       <= 1'b0;
      encrypt_ctr_data <= '0;
      out_stream_idx   <= 1'b0;
    end else begin
      encrypt_en <= valid[ROUNDS];
      if (valid[ROUNDS]) begin
        encrypt_ctr_data <= stage[ROUNDS];
        out_stream_idx   <= tag[ROUNDS];
      end
    end
  end

endmodule

// File: tb/tb_ccm_ctr_fake_aes.sv
// Directed table and random-stream checks for ccm_ctr_fake_aes.
module tb_ccm_ctr_fake_aes;

  localparam logic [127:0] KEY_FF00 = 128'hff00ff00ff00ff00ff00ff00ff00ff00;
  localparam logic [127:0] D1 = 128'hffffffff_fffeffff_ffffffff_ffffffff;
  localparam logic [127:0] D2 = 128'hffffffff_fffdffff_ffffffff_ffffffff;
  localparam logic [127:0] D3 = 128'hffffffff_fffcffff_ffffffff_ffffffff;
  localparam int NV = 26;

  logic         clk = 1'b0;
  logic         kill;
  logic [127:0] key_aes;
  logic [7:0]   ccm_ctr_flag;
  logic [3:0]   nonce_sector_id;
  logic [47:0]  nonce_frame_id;
  logic [3:0]   nonce_start_slot_idx;
  logic [7:0]   nonce_addr_idx;
  logic         in_stream_idx;
  logic         in_ready;
  logic         out_stream_idx;
  logic [127:0] encrypt_ctr_data;
  logic         encrypt_en;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         ready;
    logic         tag;
    logic         exp_en;
    logic         exp_tag;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs [NV];

  logic         q_en   [0:63];
  logic         q_tag  [0:63];
  logic [127:0] q_data [0:63];

  ccm_ctr_fake_aes dut (
    .clk(clk), .kill(kill), .key_aes(key_aes), .ccm_ctr_flag(ccm_ctr_flag),
    .nonce_sector_id(nonce_sector_id), .nonce_frame_id(nonce_frame_id),
    .nonce_start_slot_idx(nonce_start_slot_idx), .nonce_addr_idx(nonce_addr_idx),
    .in_stream_idx(in_stream_idx), .in_ready(in_ready), .out_stream_idx(out_stream_idx),
    .encrypt_ctr_data(encrypt_ctr_data), .encrypt_en(encrypt_en)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_cipher(input logic [127:0] blk, input logic [127:0] k);
    logic [127:0] d;
    logic [127:0] x;
    d = blk;
    for (int r = 0; r < 10; r++) begin
      x = d ^ k;
      d = {x[119:0], x[127:120]};
    end
    return d;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic ready, input logic tag);
    in_ready      = ready;
    in_stream_idx = tag;
  endtask

  task automatic check_output(input string name, input logic en, input logic tg, input logic [127:0] data);
    check({name, ".en"}, 128'(encrypt_en), 128'(en));
    check({name, ".tag"}, 128'(out_stream_idx), 128'(tg));
    check({name, ".data"}, encrypt_ctr_data, data);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pulse(input int idx, input logic tg, input logic [127:0] data);
    vecs[idx].exp_en   = 1'b1;
    vecs[idx].exp_tag  = tg;
    vecs[idx].exp_data = data;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic         prev;
    logic [55:0]  mctr;
    logic [127:0] blk;

    for (int i = 0; i < NV; i++) begin
      vecs[i] = '{ready: 1'b0, tag: 1'b0, exp_en: 1'b0, exp_tag: 1'b0, exp_data: '0};
    end
    // single request, 3-burst (tags 0,1,0), 2-burst + gap + 1-burst
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, '0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, '0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, '0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, '0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, '0};
    set_pulse(11, 1'b1, D1);
    set_pulse(15, 1'b0, D1);
    set_pulse(16, 1'b1, D2);
    set_pulse(17, 1'b0, D3);
    set_pulse(19, 1'b1, D1);
    set_pulse(20, 1'b1, D2);
    set_pulse(22, 1'b0, D1);
    for (int i = 1; i < NV; i++) begin
      if (!vecs[i].exp_en) begin
        vecs[i].exp_tag  = vecs[i-1].exp_tag;
        vecs[i].exp_data = vecs[i-1].exp_data;
      end
    end

    kill = 1'b0;
    key_aes = KEY_FF00;
    ccm_ctr_flag = '0; nonce_sector_id = '0; nonce_frame_id = '0;
    nonce_start_slot_idx = '0; nonce_addr_idx = '0;
    apply_stimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_output("reset", 1'b0, 1'b0, '0);
    kill = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i].ready, vecs[i].tag);
      tick();
      check_output($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_tag, vecs[i].exp_data);
    end

    // Two requests in flight, then kill three cycles later
    apply_stimulus(1'b1, 1'b1);
    tick();
    apply_stimulus(1'b1, 1'b1);
    tick();
    apply_stimulus(1'b0, 1'b0);
    repeat (3) tick();
    kill = 1'b0;
    #1;
    check_output("kill_async", 1'b0, 1'b0, '0);
    @(negedge clk);
    kill = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("post_kill%0d.en", i), 128'(encrypt_en), 128'(0));
    end

    // Irregular stream with random key, tags and nonce fields
    key_aes = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 64; i++) begin
      q_en[i] = 1'b0; q_tag[i] = 1'b0; q_data[i] = '0;
    end
    prev = 1'b0;
    mctr = '0;
    for (int i = 0; i < 62; i++) begin
      if (i < 50) begin
        apply_stimulus(($urandom % 3) != 0, 1'($urandom));
        ccm_ctr_flag         = 8'($urandom);
        nonce_sector_id      = 4'($urandom);
        nonce_frame_id       = 48'({$urandom, $urandom});
        nonce_start_slot_idx = 4'($urandom);
        nonce_addr_idx       = 8'($urandom);
      end else begin
        apply_stimulus(1'b0, 1'b0);
      end
      if (in_ready) begin
        mctr = prev ? mctr + 56'd1 : 56'd1;
        blk = {ccm_ctr_flag, nonce_sector_id, nonce_frame_id, nonce_start_slot_idx,
               nonce_addr_idx, mctr};
        q_en[i+11]   = 1'b1;
        q_tag[i+11]  = in_stream_idx;
        q_data[i+11] = ref_cipher(blk, key_aes);
      end
      prev = in_ready;
      tick();
      check($sformatf("rnd%0d.en", i), 128'(encrypt_en), 128'(q_en[i]));
      if (q_en[i]) begin
        check($sformatf("rnd%0d.tag", i), 128'(out_stream_idx), 128'(q_tag[i]));
        check($sformatf("rnd%0d.data", i), encrypt_ctr_data, q_data[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
